// File: rtl/approx_log_pkg.sv
// Shared types and constants for the Mitchell log-domain divider.
// Log values always carry F_DEF fraction bits; a narrower F zero-fills the low bits.
package approx_log_pkg;
  localparam int F_DEF = 7;
  localparam int QW    = 16;

  typedef logic        [F_DEF+2:0] logval_t;
  typedef logic signed [F_DEF+3:0] logdiff_t;
  typedef logic signed [QW-1:0]    q88_t;

  localparam q88_t Q_MAX = 16'h7FFF;
  localparam q88_t Q_MIN = 16'h8000;
endpackage

// File: rtl/approx_log_encode.sv
// Signed 8-bit operand to Mitchell log2: magnitude, leading-one detect and
// mantissa truncation to F fraction bits (left-aligned in a logval_t).
module approx_log_encode
  import approx_log_pkg::*;
#(
  parameter int F = F_DEF
) (
  input  logic [7:0] i_val,
  output logic       o_zero,
  output logval_t    o_log
);

  localparam logic [6:0] X_MASK = 7'(7'h7F << (F_DEF - F));

  logic [7:0] w_mag;
  logic [2:0] w_k;
  logic [7:0] w_norm;

  // -128 maps to 8'h80, which reads correctly as unsigned 128
  assign w_mag  = i_val[7] ? (8'd0 - i_val) : i_val;
  assign o_zero = (i_val == 8'd0);

  // Leading-one position; the highest set bit wins
  always_comb begin
    w_k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_k = w_mag[i] ? 3'(i) : w_k;
    end
  end

  assign w_norm = w_mag << (3'd7 - w_k);
  assign o_log  = {w_k, w_norm[6:0] & X_MASK};

endmodule

// File: rtl/approx_log_divider.sv
// Three-stage approximate signed divider (Mitchell): Q8.8 = A / B via log subtraction.
// Define APPROX_DIV_ROUND_EN for round-half-up on the antilog right shift.
module approx_log_divider
  import approx_log_pkg::*;
#(
  parameter int F = F_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic        div_by_zero
);

  localparam int S_OFF = 8 - F_DEF;

  logic    w_en;
  logic    w_a_zero, w_b_zero;
  logval_t w_log_a, w_log_b;

  logic    r_v1, r_sign1, r_spec1, r_dbz1;
  logic [15:0] r_specq1;
  logval_t r_loga1, r_logb1;
  logic    r_v2, r_sign2, r_spec2, r_dbz2;
  logic [15:0] r_specq2;
  logdiff_t r_d2;
  logic    r_v3, r_dbz3;
  logic [15:0] r_q3;

  logic signed [3:0] w_ki;
  logic signed [4:0] w_s;
  logic [7:0]  w_m;
  logic [3:0]  w_lsh, w_rsh;
  logic [23:0] w_m24, w_mag;
  logic [15:0] w_q;

  assign w_en     = ~r_v3 | out_ready;
  assign in_ready = w_en;

  approx_log_encode #(.F(F)) u_enc_a (.i_val(A), .o_zero(w_a_zero), .o_log(w_log_a));
  approx_log_encode #(.F(F)) u_enc_b (.i_val(B), .o_zero(w_b_zero), .o_log(w_log_b));

  // S1: encode operands and resolve the zero-operand special cases
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0; r_sign1 <= 1'b0; r_spec1 <= 1'b0; r_dbz1 <= 1'b0;
      r_specq1 <= 16'd0; r_loga1 <= '0; r_logb1 <= '0;
    end else if (w_en) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_sign1  <= A[7] ^ B[7];
        r_loga1  <= w_log_a;
        r_logb1  <= w_log_b;
        r_spec1  <= w_a_zero | w_b_zero;
        r_dbz1   <= ~w_a_zero & w_b_zero;
        r_specq1 <= w_a_zero ? 16'h0000 : (A[7] ? Q_MIN : Q_MAX);
      end
    end
  end

  // S2: log-domain subtraction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2 <= 1'b0; r_sign2 <= 1'b0; r_spec2 <= 1'b0; r_dbz2 <= 1'b0;
      r_specq2 <= 16'd0; r_d2 <= '0;
    end else if (w_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sign2  <= r_sign1;
        r_spec2  <= r_spec1;
        r_dbz2   <= r_dbz1;
        r_specq2 <= r_specq1;
        r_d2     <= logdiff_t'({1'b0, r_loga1}) - logdiff_t'({1'b0, r_logb1});
      end
    end
  end

  // Upper bits of d are floor(d / 2^F_DEF); zero-filled low bits make this F-independent
  assign w_ki  = r_d2[F_DEF+3:F_DEF];
  assign w_m   = {1'b1, r_d2[F_DEF-1:0]};
  assign w_s   = 5'(w_ki) + 5'(S_OFF);
  assign w_m24 = {16'd0, w_m};
  assign w_lsh = w_s[3:0];
  assign w_rsh = 4'(-w_s);

  // S3 comb: antilog shift, optional rounding, saturation and sign
  always_comb begin
    w_mag = 24'd0;
    w_q   = 16'd0;
    if (w_s >= 5'sd0) begin
      w_mag = w_m24 << w_lsh;
    end else begin
`ifdef APPROX_DIV_ROUND_EN
      w_mag = (w_m24 >> w_rsh) + {23'd0, w_m24[w_rsh - 4'd1]};
`else
      w_mag = w_m24 >> w_rsh;
`endif
    end
    if (r_spec2) begin
      w_q = r_specq2;
    end else if (!r_sign2) begin
      w_q = (w_mag > 24'h007FFF) ? Q_MAX : w_mag[15:0];
    end else begin
      w_q = (w_mag > 24'h008000) ? Q_MIN : 16'(24'd0 - w_mag);
    end
  end

  // S3: registered output stage, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v3 <= 1'b0; r_q3 <= 16'd0; r_dbz3 <= 1'b0;
    end else if (w_en) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_q3   <= w_q;
        r_dbz3 <= r_spec2 & r_dbz2;
      end
    end
  end

  assign out_valid   = r_v3;
  assign quotient    = r_q3;
  assign div_by_zero = r_dbz3;

endmodule
